// File: rtl/linebuffer_3x3_ctrl_pkg.sv
// Shared types and constants for the 3x3 line-buffer sequencer.
package lb_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} lb_state_e;

   localparam int LB_CFG_HW = 16;
   localparam int LB_MIN_H  = 3;
   localparam int LB_WIN    = 3;

   typedef struct packed {
      logic [LB_CFG_HW-1:0] height;
      logic                 stride;
   } lb_cfg_t;

   // (r-2) and r share the LSB, so the stride-2 phase test can use the raw counters.
   function automatic logic win_phase_ok(input logic stride, input logic r_lsb, input logic c_lsb);
      return !stride || (!r_lsb && !c_lsb);
   endfunction

endpackage

// File: rtl/linebuffer_3x3_ctrl.sv
// Raster-stream sequencer for the 3x3 line buffer: handshake, position tracking, window flagging.
// Optional LB_CTRL_PERF_CNT_EN adds the stall_cnt performance counter output.
module linebuffer_3x3_ctrl
   import lb_ctrl_pkg::*;
#(
   parameter  int LEN   = 4,
   parameter  int MAX_H = 64,
   localparam int RW    = $clog2(MAX_H),
   localparam int CW    = $clog2(LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [RW:0]   cfg_height,
   input  logic          cfg_stride,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          lb_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic          busy,
   output logic          frame_done,
   output logic          cfg_err
`ifdef LB_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]   stall_cnt
`endif
);

   lb_state_e     state_q, state_d;
   lb_cfg_t       cfg_q, cfg_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          out_valid_q, out_valid_d;
   logic [RW-1:0] out_row_q, out_row_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic          frame_done_q, frame_done_d;
   logic          cfg_err_q, cfg_err_d;

   logic accept, win_hit, cfg_legal, last_pix;

   assign cfg_legal = (cfg_height >= (RW+1)'(LB_MIN_H)) && (cfg_height <= (RW+1)'(MAX_H));
   assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign win_hit   = accept && (row_q >= RW'(LB_WIN-1)) && (col_q >= CW'(LB_WIN-1))
                      && win_phase_ok(cfg_q.stride, row_q[0], col_q[0]);
   assign last_pix  = (LB_CFG_HW'(row_q) == cfg_q.height - LB_CFG_HW'(1)) && (col_q == CW'(LEN-1));

   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      row_d        = row_q;
      col_d        = col_q;
      out_valid_d  = out_valid_q;
      out_row_d    = out_row_q;
      out_col_d    = out_col_q;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;

      if (accept) begin
         if (col_q == CW'(LEN-1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      // A new window reloads the output register even while the old one is being consumed.
      if (win_hit) begin
         out_valid_d = 1'b1;
         out_row_d   = row_q - RW'(LB_WIN-1);
         out_col_d   = col_q - CW'(LB_WIN-1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_legal) begin
                  state_d      = RUN;
                  cfg_d.height = LB_CFG_HW'(cfg_height);
                  cfg_d.stride = cfg_stride;
                  row_d        = '0;
                  col_d        = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN:     if (accept && last_pix) state_d = DRAIN;
         DRAIN:   if (!out_valid_q || out_ready) state_d = DONE;
         DONE: begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cfg_q        <= '0;
         row_q        <= '0;
         col_q        <= '0;
         out_valid_q  <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         row_q        <= row_d;
         col_q        <= col_d;
         out_valid_q  <= out_valid_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign lb_en      = accept;
   assign out_valid  = out_valid_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;

`ifdef LB_CTRL_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        stall;

   always_comb begin
      stall       = ((state_q == RUN) && in_valid && !in_ready) || (out_valid_q && !out_ready);
      stall_cnt_d = stall_cnt_q;
      if ((state_q == IDLE) && start && cfg_legal) begin
         stall_cnt_d = '0;
      end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// Directed self-checking bench for linebuffer_3x3_ctrl (LEN=4, MAX_H=64); windows encoded as row*16+col.
module tb_linebuffer_3x3_ctrl;

   localparam int LEN   = 4;
   localparam int MAX_H = 64;
   localparam int RW    = 6;
   localparam int CW    = 2;

   logic          clk = 1'b0;
   logic          rst, start, cfg_stride, in_valid, out_ready;
   logic [RW:0]   cfg_height;
   logic          in_ready, lb_en, out_valid, busy, frame_done, cfg_err;
   logic [RW-1:0] out_row;
   logic [CW-1:0] out_col;
`ifdef LB_CTRL_PERF_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   always #5 clk = ~clk;

   linebuffer_3x3_ctrl #(.LEN(LEN), .MAX_H(MAX_H)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
      .in_valid(in_valid), .in_ready(in_ready), .lb_en(lb_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_row(out_row), .out_col(out_col), .busy(busy),
      .frame_done(frame_done), .cfg_err(cfg_err)
`ifdef LB_CTRL_PERF_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc, acc_cnt, first_ov_acc, last_win_cyc, done_cyc;
   int wins[$];
   bit ok;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_rec();
      cyc = 0; acc_cnt = 0; first_ov_acc = -1; last_win_cyc = -1; done_cyc = -1;
      wins.delete();
   endtask

   task automatic record();
      cyc++;
      if (out_valid === 1'b1 && first_ov_acc < 0) first_ov_acc = acc_cnt;
      if (lb_en === 1'b1) acc_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         wins.push_back(int'(out_row) * 16 + int'(out_col));
         last_win_cyc = cyc;
      end
      if (frame_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
   endtask

   task automatic step();
      @(negedge clk); record();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int h, input logic s);
      start = 1'b1; cfg_height = (RW+1)'(h); cfg_stride = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_cyc >= 0) break;
      end
      chk({tag, "_done_seen"}, done_cyc >= 0, 1);
   endtask

   task automatic check_wins(input string tag, input int n, input int e0, input int e1, input int e2, input int e3);
      int e[4];
      e = '{e0, e1, e2, e3};
      chk({tag, "_win_count"}, wins.size(), n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_win%0d", tag, i), (i < wins.size()) ? wins[i] : -1, e[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; cfg_height = '0; cfg_stride = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_lb_en", lb_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_col", out_col, 0);
      rst = 1'b0;

      // Test 1: H=4, stride 1, free-running
      in_valid = 1'b1; clear_rec();
      do_start(4, 1'b0);
      chk("t1_busy", busy, 1);
      chk("t1_in_ready", in_ready, 1);
      run_frame("t1", 60);
      chk("t1_accepts", acc_cnt, 16);
      chk("t1_first_win_after", first_ov_acc, 11);
      check_wins("t1", 4, 0, 1, 16, 17);
      chk("t1_done_gap", done_cyc - last_win_cyc, 2);
      chk("t1_idle_busy", busy, 0);
      chk("t1_done_pulse", frame_done, 0);
      $display("t1 done: accepts=%0d windows=%0d", acc_cnt, wins.size());

      // Test 2: H=6, stride 2
      clear_rec();
      do_start(6, 1'b1);
      run_frame("t2", 80);
      chk("t2_accepts", acc_cnt, 24);
      check_wins("t2", 2, 0, 32, 0, 0);
      $display("t2 done: accepts=%0d windows=%0d", acc_cnt, wins.size());

      // Test 3: hold the first window for 5 cycles
      clear_rec(); ok = 1'b0;
      do_start(4, 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            out_ready = 1'b0; ok = 1'b1;
            break;
         end
         record();
         @(posedge clk); #1;
      end
      chk("t3_window_reached", ok, 1);
      chk("t3_accepts_before", acc_cnt, 11);
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t3_in_ready_%0d", k), in_ready, 0);
         chk($sformatf("t3_lb_en_%0d", k), lb_en, 0);
         chk($sformatf("t3_out_valid_%0d", k), out_valid, 1);
         chk($sformatf("t3_out_row_%0d", k), out_row, 0);
         chk($sformatf("t3_out_col_%0d", k), out_col, 0);
         if (k < 4) begin
            @(negedge clk); #1;
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
`ifdef LB_CTRL_PERF_CNT_EN
      chk("t3_stall_cnt", stall_cnt, 5);
`endif
      run_frame("t3", 60);
      chk("t3_accepts", acc_cnt, 16);
      check_wins("t3", 4, 0, 1, 16, 17);
      $display("t3 done: accepts=%0d windows=%0d", acc_cnt, wins.size());

      // Test 4: illegal heights, legal minimum height, start during RUN
      do_start(2, 1'b0);
      chk("t4_err_h2", cfg_err, 1);
      chk("t4_busy_h2", busy, 0);
      chk("t4_in_ready_h2", in_ready, 0);
      @(posedge clk); #1;
      chk("t4_err_pulse", cfg_err, 0);
      chk("t4_busy_after", busy, 0);
`ifdef LB_CTRL_PERF_CNT_EN
      chk("t4_stall_kept", stall_cnt, 5);
`endif
      do_start(65, 1'b0);
      chk("t4_err_h65", cfg_err, 1);
      chk("t4_busy_h65", busy, 0);
      @(posedge clk); #1;
      clear_rec();
      do_start(3, 1'b0);
`ifdef LB_CTRL_PERF_CNT_EN
      chk("t4_stall_cleared", stall_cnt, 0);
`endif
      run_frame("t4h3", 60);
      chk("t4h3_accepts", acc_cnt, 12);
      check_wins("t4h3", 2, 0, 1, 0, 0);
      clear_rec();
      do_start(4, 1'b0);
      for (int i = 0; i < 5; i++) step();
      start = 1'b1; cfg_height = 7'd6; cfg_stride = 1'b1;
      step();
      start = 1'b0; cfg_stride = 1'b0;
      chk("t4_restart_err", cfg_err, 0);
      chk("t4_restart_busy", busy, 1);
      run_frame("t4run", 60);
      chk("t4run_accepts", acc_cnt, 16);
      check_wins("t4run", 4, 0, 1, 16, 17);
      $display("t4 done: accepts=%0d windows=%0d", acc_cnt, wins.size());

      // Test 5: reset mid-frame, then a clean frame
      clear_rec();
      do_start(4, 1'b0);
      for (int i = 0; i < 30; i++) begin
         step();
         if (acc_cnt >= 9) break;
      end
      chk("t5_accepts_pre", acc_cnt, 9);
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_in_ready", in_ready, 0);
      chk("t5_frame_done", frame_done, 0);
      in_valid = 1'b1; clear_rec();
      do_start(4, 1'b0);
      run_frame("t5", 60);
      chk("t5_accepts", acc_cnt, 16);
      check_wins("t5", 4, 0, 1, 16, 17);
      $display("t5 done: accepts=%0d windows=%0d", acc_cnt, wins.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
